// File: rtl/olivia_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_e   : sequencer states
//   BYTES_PER_INSTR : bytes assembled per instruction word
//   IMEM_ADDR_W     : byte address width of the instruction memory
//   pc_is_bad()     : true for a misaligned PC or one outside the memory
package olivia_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  localparam int BYTES_PER_INSTR = 4;
  localparam int IMEM_ADDR_W     = 6;

  function automatic logic pc_is_bad(input logic [63:0] pc, input int unsigned addr_w);
    logic [63:0] w_hi;
    w_hi = pc >> addr_w;
    return (pc[1:0] != 2'b00) || (w_hi != 64'd0);
  endfunction

endpackage

// File: rtl/ifetch_word_assembler.sv
// Byte counter and big-endian word builder for one instruction fetch.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : discard the partial/held word and restart the counter
//   i_issue    : a read for byte o_cnt is issued this cycle
//   i_drain    : the last byte's read data is on i_rdata this cycle
//   i_rdata    : memory read data (belongs to the previous cycle's issue)
//   o_cnt      : index of the byte being issued
//   o_word     : assembled word, byte k at bits [31-8k -: 8]
module ifetch_word_assembler
  import olivia_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_issue,
  input  logic        i_drain,
  input  logic [7:0]  i_rdata,
  output logic [1:0]  o_cnt,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        w_capture;
  logic [1:0]  w_slot;

  // Read data lags its issue by one cycle: during issue of byte cnt the bus
  // carries byte cnt-1, and during drain it carries the last byte.
  always_comb begin
    w_capture = (i_issue && (r_cnt != 2'd0)) || i_drain;
    // slot numbers byte lanes from the LSB end, so byte k sits in slot 3-k
    w_slot    = i_drain ? (LAST_BYTE - LAST_BYTE) : (LAST_BYTE - (r_cnt - 2'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clr) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else begin
      if (i_issue) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_capture) begin
        r_word[{w_slot, 3'b000} +: 8] <= i_rdata;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_word = r_word;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer for a byte-wide instruction memory. Shares the single
// memory port between a byte loader (IDLE only) and 4-byte instruction
// fetch, assembles big-endian words and presents them on a valid/ready
// output. Owns the PC: +4 advance on transfer, redirect, fault on bad PC.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   fetch_en                           : allow new fetches (looked at in IDLE/HOLD)
//   redirect_valid, redirect_pc        : load new PC, drop any word in flight
//   out_valid/out_ready/out_instr/out_pc : instruction output handshake
//   load_valid/load_ready/load_addr/load_data : loader byte writes
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory byte port (sync read)
//   fault                              : PC was bad; held until redirect/reset
module instruction_fetch_ctrl
  import olivia_fetch_pkg::*;
#(
  parameter int          ADDR_W   = IMEM_ADDR_W,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [63:0]       out_pc,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              fault
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

  fetch_state_e        r_state, w_state_nxt;
  logic [63:0]         r_pc, w_pc_nxt, w_pc_plus4;
  logic                r_out_valid;
  logic [63:0]         r_out_pc;
  logic [1:0]          w_cnt;
  logic [31:0]         w_word;
  logic                w_handshake;
  logic                w_issue, w_drain;
  logic                w_mem_en, w_mem_we, w_load_ready;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [7:0]          w_mem_wdata;

  assign w_pc_plus4  = r_pc + 64'd4;
  assign w_handshake = (r_state == HOLD) && r_out_valid && out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = 8'd0;
    w_load_ready = 1'b0;
    w_issue      = 1'b0;
    w_drain      = 1'b0;

    case (r_state)
      IDLE: begin
        w_load_ready = 1'b1;
        if (load_valid) begin
          // loader has priority over starting a fetch
          w_mem_en    = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = load_addr;
          w_mem_wdata = load_data;
        end else if (fetch_en) begin
          w_state_nxt = pc_is_bad(r_pc, unsigned'(ADDR_W)) ? FAULT : FETCH;
        end
      end
      FETCH: begin
        w_mem_en   = 1'b1;
        w_mem_addr = r_pc[ADDR_W-1:0] + ADDR_W'(w_cnt);
        w_issue    = 1'b1;
        if (w_cnt == LAST_BYTE) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_drain     = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_handshake) begin
          w_pc_nxt = w_pc_plus4;
          if (!fetch_en) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = pc_is_bad(w_pc_plus4, unsigned'(ADDR_W)) ? FAULT : FETCH;
          end
        end
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Redirect overrides whatever the state decided, including a +4 from a
    // simultaneous handshake. A loader write in IDLE still keeps us in IDLE.
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
      if (!((r_state == IDLE) && load_valid)) begin
        if (!fetch_en) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = pc_is_bad(redirect_pc, unsigned'(ADDR_W)) ? FAULT : FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (redirect_valid) begin
        r_out_valid <= 1'b0;
      end else if (w_drain) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= r_pc;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  ifetch_word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (redirect_valid),
    .i_issue (w_issue),
    .i_drain (w_drain),
    .i_rdata (mem_rdata),
    .o_cnt   (w_cnt),
    .o_word  (w_word)
  );

  // The port is quiet while reset is held, even though the state is IDLE.
  assign mem_en     = rst_n & w_mem_en;
  assign mem_we     = rst_n & w_mem_we;
  assign mem_addr   = rst_n ? w_mem_addr : '0;
  assign mem_wdata  = rst_n ? w_mem_wdata : 8'd0;
  assign load_ready = rst_n & w_load_ready;

  assign out_valid  = r_out_valid;
  assign out_instr  = w_word;
  assign out_pc     = r_out_pc;
  assign fault      = (r_state == FAULT);

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
module tb_instruction_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [5:0]  load_addr = 6'd0;
  logic [7:0]  load_data = 8'd0;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        fault;

  int n_cmp = 0;
  int n_fail = 0;

  instruction_fetch_ctrl #(.ADDR_W(6), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fault(fault)
  );

  always #5 clk = ~clk;

  // 64-byte synchronous-read memory model
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // advance until out_valid, at most max_cyc edges; n = edges taken
  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      @(posedge clk);
      #2;
      n++;
      if (out_valid) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_valid: got no out_valid, expected one within %0d cycles", max_cyc);
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } load_vec_t;

  typedef struct {
    logic        x_en;
    logic [5:0]  x_addr;
    logic        x_ov;
    logic [31:0] x_instr;
    logic [63:0] x_pc;
  } trace_vec_t;

  load_vec_t  lv [16];
  trace_vec_t tv [13];
  int n;

  initial begin
    for (int i = 0; i < 16; i++) begin
      lv[i].addr = 6'(i);
      lv[i].data = 8'(i);
    end
    // cycle-by-cycle trace from the cycle fetch_en rises (out_ready held 1)
    tv[0]  = '{1'b0, 6'd0, 1'b0, 32'h0, 64'h0};
    tv[1]  = '{1'b1, 6'd0, 1'b0, 32'h0, 64'h0};
    tv[2]  = '{1'b1, 6'd1, 1'b0, 32'h0, 64'h0};
    tv[3]  = '{1'b1, 6'd2, 1'b0, 32'h0, 64'h0};
    tv[4]  = '{1'b1, 6'd3, 1'b0, 32'h0, 64'h0};
    tv[5]  = '{1'b0, 6'd0, 1'b0, 32'h0, 64'h0};
    tv[6]  = '{1'b0, 6'd0, 1'b1, 32'h00010203, 64'h0};
    tv[7]  = '{1'b1, 6'd4, 1'b0, 32'h0, 64'h0};
    tv[8]  = '{1'b1, 6'd5, 1'b0, 32'h0, 64'h0};
    tv[9]  = '{1'b1, 6'd6, 1'b0, 32'h0, 64'h0};
    tv[10] = '{1'b1, 6'd7, 1'b0, 32'h0, 64'h0};
    tv[11] = '{1'b0, 6'd0, 1'b0, 32'h0, 64'h0};
    tv[12] = '{1'b0, 6'd0, 1'b1, 32'h04050607, 64'h4};

    // reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;

    // loader writes: table for 0..15, remaining bytes get their own address
    for (int i = 0; i < 64; i++) begin
      cyc();
      load_valid = 1'b1;
      load_addr  = (i < 16) ? lv[i].addr : 6'(i);
      load_data  = (i < 16) ? lv[i].data : 8'(i);
      #1;
      chk($sformatf("load%0d_port", i), {43'd0, load_ready, mem_en, mem_we, mem_addr, mem_wdata},
          {43'd0, 1'b1, 1'b1, 1'b1, 6'(i), 8'(i)});
    end
    cyc();
    load_valid = 1'b0;

    // fetch trace
    for (int i = 0; i < 13; i++) begin
      if (i != 0) cyc();
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk($sformatf("tr%0d_mem_en", i), 64'(mem_en), 64'(tv[i].x_en));
      chk($sformatf("tr%0d_mem_addr", i), 64'(mem_addr), 64'(tv[i].x_addr));
      chk($sformatf("tr%0d_out_valid", i), 64'(out_valid), 64'(tv[i].x_ov));
      if (tv[i].x_ov) begin
        chk($sformatf("tr%0d_out_instr", i), 64'(out_instr), 64'(tv[i].x_instr));
        chk($sformatf("tr%0d_out_pc", i), out_pc, tv[i].x_pc);
      end
    end

    // stall with a word presented
    cyc();
    out_ready = 1'b0;
    wait_valid(10, n);
    chk("stall_instr", 64'(out_instr), 64'h08090A0B);
    chk("stall_pc", out_pc, 64'h8);
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("stall_hold", {out_valid, out_instr, out_pc[15:0], mem_en, load_ready},
          {1'b1, 32'h08090A0B, 16'h0008, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    cyc(); out_ready = 1'b0; #1;
    chk("after_stall_addr", 64'(mem_addr), 64'h0C);
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8;
    #1;
    chk("redir_cnt2_addr", 64'(mem_addr), 64'h0E);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("redir_first_read", {mem_en, mem_we, mem_addr, out_valid}, {1'b1, 1'b0, 6'h08, 1'b0});
    wait_valid(10, n);
    chk("redir_latency", 64'(n), 64'd5);
    chk("redir_instr", 64'(out_instr), 64'h08090A0B);
    chk("redir_pc", out_pc, 64'h8);

    // misaligned redirect faults, then recovery
    redirect_valid = 1'b1;
    redirect_pc    = 64'h6;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("fault_set", {fault, mem_en, out_valid}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("fault_stay", {fault, mem_en, out_valid, load_ready}, {1'b1, 1'b0, 1'b0, 1'b0});
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("fault_clear", {fault, mem_en, mem_addr}, {1'b0, 1'b1, 6'h00});
    wait_valid(10, n);
    chk("recover_instr", 64'(out_instr), 64'h00010203);
    chk("recover_pc", out_pc, 64'h0);

    // drop held word, run to end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 64'h38;
    out_ready      = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("drop_held", {out_valid, mem_addr}, {1'b0, 6'h38});
    wait_valid(10, n);
    chk("w38_instr", 64'(out_instr), 64'h38393A3B);
    chk("w38_pc", out_pc, 64'h38);
    wait_valid(10, n);
    chk("w3c_instr", 64'(out_instr), 64'h3C3D3E3F);
    chk("w3c_pc", out_pc, 64'h3C);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("pc40_fault", {fault, mem_en, out_valid}, {1'b1, 1'b0, 1'b0});
    end

    // back to IDLE; loader and fetch_en together
    redirect_valid = 1'b1;
    redirect_pc    = 64'h10;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("idle_entry", {fault, load_ready, mem_en}, {1'b0, 1'b1, 1'b0});
    load_valid = 1'b1;
    fetch_en   = 1'b1;
    load_addr  = 6'h20;
    load_data  = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("load_wins", {load_ready, mem_en, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b1, 1'b1, 6'h20, 8'hA5});
      cyc();
    end
    load_valid = 1'b0;
    #1;
    chk("load_drop_idle", {load_ready, mem_en}, {1'b1, 1'b0});
    cyc(); #1;
    chk("fetch_after_load", {load_ready, mem_en, mem_we, mem_addr}, {1'b0, 1'b1, 1'b0, 6'h10});
    wait_valid(10, n);
    chk("w10_instr", 64'(out_instr), 64'h10111213);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h20;
    cyc();
    redirect_valid = 1'b0;
    wait_valid(10, n);
    chk("w20_instr", 64'(out_instr), 64'hA5212223);
    chk("w20_pc", out_pc, 64'h20);

    // asynchronous reset in DRAIN
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("drain_reached", {mem_en, out_valid}, {1'b0, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("async_rst", {out_valid, fault, mem_en, load_ready, mem_addr, out_instr, out_pc},
        {1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 64'h0});
    cyc(); cyc();
    rst_n     = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("post_rst_idle", {load_ready, mem_en}, {1'b1, 1'b0});
    cyc(); #1;
    chk("post_rst_pc", {mem_en, mem_addr}, {1'b1, 6'h00});
    wait_valid(10, n);
    chk("post_rst_instr", 64'(out_instr), 64'h00010203);
    chk("post_rst_out_pc", out_pc, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
